// File: rtl/boxhead_pkg.sv
// Shared types and default geometry for the enemy combat slice.
// Coordinates are 9-bit screen pixels; overlap math is widened to 11 bits.
package boxhead_pkg;

    typedef enum logic [1:0] {
        DIR_DOWN  = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_UP    = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_e;

    localparam int DEF_ATTACK_SHORT = 16;
    localparam int DEF_ATTACK_LONG  = 80;
    localparam int DEF_ENEMY_W      = 26;
    localparam int DEF_ENEMY_H      = 26;

    localparam int COORD_W   = 9;
    localparam int CMP_W     = 11;
    localparam int HP_W      = 7;
    localparam int RESPAWN_W = 10;

    function automatic logic [HP_W-1:0] hp_after_hit(input logic [HP_W-1:0] hp,
                                                     input logic [HP_W-1:0] dmg);
        return (hp > dmg) ? hp - dmg : '0;
    endfunction

endpackage

// File: rtl/attack_hitbox.sv
// Combinational overlap test between the directional attack box and one enemy box.
// Every subtraction is rewritten as an addition on the enemy side, so nothing wraps near 0.
module attack_hitbox
    import boxhead_pkg::*;
#(
    parameter int ATTACK_SHORT = DEF_ATTACK_SHORT,
    parameter int ATTACK_LONG  = DEF_ATTACK_LONG,
    parameter int ENEMY_W      = DEF_ENEMY_W,
    parameter int ENEMY_H      = DEF_ENEMY_H
) (
    input  dir_e               dir,
    input  logic [COORD_W-1:0] attack_x,
    input  logic [COORD_W-1:0] attack_y,
    input  logic [COORD_W-1:0] enemy_x,
    input  logic [COORD_W-1:0] enemy_y,
    output logic               hit
);

    logic [CMP_W-1:0] ax, ay, ex, ey;
    logic [CMP_W-1:0] s, l, w, h;
    logic             x_ok, y_ok;

    assign ax = {2'b00, attack_x};
    assign ay = {2'b00, attack_y};
    assign ex = {2'b00, enemy_x};
    assign ey = {2'b00, enemy_y};
    assign s  = CMP_W'(ATTACK_SHORT);
    assign l  = CMP_W'(ATTACK_LONG);
    assign w  = CMP_W'(ENEMY_W);
    assign h  = CMP_W'(ENEMY_H);

    always_comb begin
        x_ok = 1'b0;
        y_ok = 1'b0;
        case (dir)
            DIR_DOWN: begin
                x_ok = (ex <= ax + s) && (ex + w >= ax);
                y_ok = (ey <= ay + l) && (ey + h >= ay);
            end
            // Box starts at AX-L: compare EX+W+L against AX instead.
            DIR_LEFT: begin
                x_ok = (ex <= ax) && (ex + w + l >= ax);
                y_ok = (ey <= ay + s) && (ey + h >= ay);
            end
            DIR_UP: begin
                x_ok = (ex <= ax + s) && (ex + w >= ax);
                y_ok = (ey <= ay) && (ey + h + l >= ay);
            end
            DIR_RIGHT: begin
                x_ok = (ex <= ax + l) && (ex + w >= ax);
                y_ok = (ey <= ay + s) && (ey + h >= ay);
            end
            default: begin
                x_ok = 1'b0;
                y_ok = 1'b0;
            end
        endcase
    end

    assign hit = x_ok & y_ok;

endmodule

// File: rtl/enemy_combat.sv
// Attack scanner: one press sweeps all enemies, one per cycle, applying damage,
// counting kills, and respawning dead enemies on a frame-derived tick.
module enemy_combat
    import boxhead_pkg::*;
#(
    parameter int ENEMY_NUM    = 8,
    parameter int HP_MAX       = 100,
    parameter int DAMAGE       = 50,
    parameter int RESPAWN_TIME = 200,
    parameter int FRAME_DIV    = 4,
    parameter int ATTACK_SHORT = DEF_ATTACK_SHORT,
    parameter int ATTACK_LONG  = DEF_ATTACK_LONG,
    parameter int ENEMY_W      = DEF_ENEMY_W,
    parameter int ENEMY_H      = DEF_ENEMY_H
) (
    input  logic                         Clk,
    input  logic                         Reset_n,
    input  logic                         frame_clk,
    input  logic                         Attack_On,
    input  logic [1:0]                   Player_Direction,
    input  logic [COORD_W-1:0]           Attack_X,
    input  logic [COORD_W-1:0]           Attack_Y,
    input  logic [ENEMY_NUM*COORD_W-1:0] Enemy_X,
    input  logic [ENEMY_NUM*COORD_W-1:0] Enemy_Y,
    output logic [ENEMY_NUM-1:0]         Enemy_Alive,
    output logic [ENEMY_NUM-1:0]         Enemy_Hit,
    output logic [7:0]                   Score,
    output logic                         Busy
);

    logic                 frame_q, frame_d;
    logic                 atk_q, atk_d;
    logic [15:0]          div_q, div_d;
    state_e               state_q, state_d;
    logic [3:0]           idx_q, idx_d;
    dir_e                 dir_q, dir_d;
    logic [COORD_W-1:0]   ax_q, ax_d, ay_q, ay_d;
    logic [HP_W-1:0]      hp_q  [ENEMY_NUM];
    logic [HP_W-1:0]      hp_d  [ENEMY_NUM];
    logic [RESPAWN_W-1:0] cnt_q [ENEMY_NUM];
    logic [RESPAWN_W-1:0] cnt_d [ENEMY_NUM];
    logic [ENEMY_NUM-1:0] hit_q, hit_d;
    logic [7:0]           score_q, score_d;

    logic                 frame_edge, tick, atk_event;
    logic                 box_hit, scan_hit;
    logic [COORD_W-1:0]   sel_x, sel_y;
    logic [HP_W-1:0]      sel_hp, hp_new;

    always_comb begin
        sel_x  = '0;
        sel_y  = '0;
        sel_hp = '0;
        for (int i = 0; i < ENEMY_NUM; i++) begin
            if (idx_q == 4'(i)) begin
                sel_x  = Enemy_X[i*COORD_W +: COORD_W];
                sel_y  = Enemy_Y[i*COORD_W +: COORD_W];
                sel_hp = hp_q[i];
            end
        end
    end

    attack_hitbox #(
        .ATTACK_SHORT (ATTACK_SHORT),
        .ATTACK_LONG  (ATTACK_LONG),
        .ENEMY_W      (ENEMY_W),
        .ENEMY_H      (ENEMY_H)
    ) u_hitbox (
        .dir      (dir_q),
        .attack_x (ax_q),
        .attack_y (ay_q),
        .enemy_x  (sel_x),
        .enemy_y  (sel_y),
        .hit      (box_hit)
    );

    always_comb begin
        frame_d    = frame_clk;
        atk_d      = Attack_On;
        frame_edge = frame_clk & ~frame_q;
        tick       = frame_edge && (div_q == 16'(FRAME_DIV - 1));
        atk_event  = Attack_On & ~atk_q;

        div_d = div_q;
        if (frame_edge) begin
            div_d = tick ? '0 : div_q + 16'd1;
        end

        state_d = state_q;
        idx_d   = idx_q;
        dir_d   = dir_q;
        ax_d    = ax_q;
        ay_d    = ay_q;
        case (state_q)
            ST_IDLE: begin
                if (atk_event) begin
                    state_d = ST_SCAN;
                    idx_d   = '0;
                    dir_d   = dir_e'(Player_Direction);
                    ax_d    = Attack_X;
                    ay_d    = Attack_Y;
                end
            end
            // New presses are dropped here; the captured box stays frozen.
            ST_SCAN: begin
                if (idx_q == 4'(ENEMY_NUM - 1)) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        scan_hit = (state_q == ST_SCAN) && box_hit && (sel_hp != '0);
        hp_new   = hp_after_hit(sel_hp, HP_W'(DAMAGE));

        score_d = score_q;
        if (scan_hit && (hp_new == '0) && (score_q != 8'hFF)) begin
            score_d = score_q + 8'd1;
        end

        // Hits need alive and respawn ticks need dead, so the two never collide.
        for (int i = 0; i < ENEMY_NUM; i++) begin
            hp_d[i]  = hp_q[i];
            cnt_d[i] = cnt_q[i];
            hit_d[i] = 1'b0;
            if (scan_hit && (idx_q == 4'(i))) begin
                hp_d[i]  = hp_new;
                hit_d[i] = 1'b1;
            end
            if ((hp_q[i] == '0) && tick) begin
                if (cnt_q[i] == RESPAWN_W'(RESPAWN_TIME - 1)) begin
                    cnt_d[i] = '0;
                    hp_d[i]  = HP_W'(HP_MAX);
                end else begin
                    cnt_d[i] = cnt_q[i] + RESPAWN_W'(1);
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            frame_q <= 1'b0;
            atk_q   <= 1'b0;
            div_q   <= '0;
            state_q <= ST_IDLE;
            idx_q   <= '0;
            dir_q   <= DIR_DOWN;
            ax_q    <= '0;
            ay_q    <= '0;
            hit_q   <= '0;
            score_q <= '0;
            for (int i = 0; i < ENEMY_NUM; i++) begin
                hp_q[i]  <= HP_W'(HP_MAX);
                cnt_q[i] <= '0;
            end
        end else begin
            frame_q <= frame_d;
            atk_q   <= atk_d;
            div_q   <= div_d;
            state_q <= state_d;
            idx_q   <= idx_d;
            dir_q   <= dir_d;
            ax_q    <= ax_d;
            ay_q    <= ay_d;
            hit_q   <= hit_d;
            score_q <= score_d;
            for (int i = 0; i < ENEMY_NUM; i++) begin
                hp_q[i]  <= hp_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        Enemy_Alive = '0;
        for (int i = 0; i < ENEMY_NUM; i++) begin
            Enemy_Alive[i] = (hp_q[i] != '0);
        end
    end

    assign Enemy_Hit = hit_q;
    assign Score     = score_q;
    assign Busy      = (state_q == ST_SCAN);

endmodule

// File: tb/tb_enemy_combat.sv
// Directed bench for enemy_combat: damage, kill scoring, respawn timing,
// edge clipping near 0, scan ordering and mid-scan reset.
module tb_enemy_combat;

    localparam int N = 8;

    logic         Clk;
    logic         Reset_n;
    logic         frame_clk;
    logic         Attack_On;
    logic [1:0]   Player_Direction;
    logic [8:0]   Attack_X, Attack_Y;
    logic [N*9-1:0] Enemy_X, Enemy_Y;
    logic [N-1:0] Enemy_Alive, Enemy_Hit;
    logic [7:0]   Score;
    logic         Busy;

    int n_checks = 0;
    int n_errors = 0;

    int hit_cnt [N];
    int busy_cnt = 0;
    int hit_log [$];
    int snap_hits [N];
    int snap_busy;
    int log_base;

    enemy_combat dut (
        .Clk              (Clk),
        .Reset_n          (Reset_n),
        .frame_clk        (frame_clk),
        .Attack_On        (Attack_On),
        .Player_Direction (Player_Direction),
        .Attack_X         (Attack_X),
        .Attack_Y         (Attack_Y),
        .Enemy_X          (Enemy_X),
        .Enemy_Y          (Enemy_Y),
        .Enemy_Alive      (Enemy_Alive),
        .Enemy_Hit        (Enemy_Hit),
        .Score            (Score),
        .Busy             (Busy)
    );

    // clock
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // monitor: cumulative pulse counts sampled away from the active edge
    initial for (int i = 0; i < N; i++) hit_cnt[i] = 0;
    always @(negedge Clk) begin
        if (Busy) busy_cnt++;
        for (int i = 0; i < N; i++) begin
            if (Enemy_Hit[i]) begin
                hit_cnt[i]++;
                hit_log.push_back(i);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        cycles(3);
        Reset_n = 1'b1;
        cycles(1);
    endtask

    task automatic set_enemy(input int i, input int x, input int y);
        Enemy_X[i*9 +: 9] = 9'(x);
        Enemy_Y[i*9 +: 9] = 9'(y);
    endtask

    task automatic park_all();
        for (int i = 0; i < N; i++) set_enemy(i, 400, 400);
    endtask

    task automatic press();
        Attack_On = 1'b1;
        cycles(1);
        Attack_On = 1'b0;
        cycles(N + 3);
    endtask

    task automatic frame_edges(input int n);
        for (int k = 0; k < n; k++) begin
            frame_clk = 1'b1;
            cycles(1);
            frame_clk = 1'b0;
            cycles(1);
        end
    endtask

    task automatic snap();
        for (int i = 0; i < N; i++) snap_hits[i] = hit_cnt[i];
        snap_busy = busy_cnt;
        log_base  = hit_log.size();
    endtask

    initial begin
        Reset_n          = 1'b0;
        frame_clk        = 1'b0;
        Attack_On        = 1'b0;
        Player_Direction = 2'd0;
        Attack_X         = '0;
        Attack_Y         = '0;
        Enemy_X          = '0;
        Enemy_Y          = '0;
        park_all();
        do_reset();

        // reset state
        check("rst_alive", 32'(Enemy_Alive), 32'hFF);
        check("rst_hit",   32'(Enemy_Hit),   32'h0);
        check("rst_score", 32'(Score),       32'd0);
        check("rst_busy",  32'(Busy),        32'd0);

        // right attack, two presses kill enemy 0
        Player_Direction = 2'd3;
        Attack_X = 9'd100;
        Attack_Y = 9'd100;
        set_enemy(0, 150, 105);
        snap();
        press();
        check("r1_hits0",  32'(hit_cnt[0] - snap_hits[0]), 32'd1);
        check("r1_alive",  32'(Enemy_Alive), 32'hFF);
        check("r1_score",  32'(Score), 32'd0);
        check("r1_busy",   32'(busy_cnt - snap_busy), 32'd8);
        press();
        check("r2_hits0",  32'(hit_cnt[0] - snap_hits[0]), 32'd2);
        check("r2_alive",  32'(Enemy_Alive), 32'hFE);
        check("r2_score",  32'(Score), 32'd1);
        press();
        check("r3_dead_nohit", 32'(hit_cnt[0] - snap_hits[0]), 32'd2);
        check("r3_score",  32'(Score), 32'd1);

        // respawn on the 800th frame edge (divider untouched since reset)
        frame_edges(799);
        check("resp_799_dead", 32'(Enemy_Alive[0]), 32'd0);
        frame_edges(1);
        check("resp_800_alive", 32'(Enemy_Alive), 32'hFF);
        check("resp_score", 32'(Score), 32'd1);

        // held button: one hit only, then one more press kills (HP was 50)
        snap();
        Attack_On = 1'b1;
        cycles(500);
        check("held_hits", 32'(hit_cnt[0] - snap_hits[0]), 32'd1);
        check("held_alive", 32'(Enemy_Alive[0]), 32'd1);
        Attack_On = 1'b0;
        cycles(2);
        press();
        check("held_kill_hits", 32'(hit_cnt[0] - snap_hits[0]), 32'd2);
        check("held_kill_alive", 32'(Enemy_Alive[0]), 32'd0);
        check("held_score", 32'(Score), 32'd2);

        // left attack near origin plus inclusive boundaries
        do_reset();
        park_all();
        Player_Direction = 2'd1;
        Attack_X = 9'd10;
        Attack_Y = 9'd10;
        set_enemy(0, 0, 5);
        set_enemy(1, 100, 5);
        set_enemy(2, 10, 5);
        set_enemy(3, 11, 5);
        set_enemy(4, 5, 26);
        set_enemy(5, 5, 27);
        snap();
        press();
        check("left_e0_hit",   32'(hit_cnt[0] - snap_hits[0]), 32'd1);
        check("left_e1_miss",  32'(hit_cnt[1] - snap_hits[1]), 32'd0);
        check("left_e2_xedge", 32'(hit_cnt[2] - snap_hits[2]), 32'd1);
        check("left_e3_xout",  32'(hit_cnt[3] - snap_hits[3]), 32'd0);
        check("left_e4_yedge", 32'(hit_cnt[4] - snap_hits[4]), 32'd1);
        check("left_e5_yout",  32'(hit_cnt[5] - snap_hits[5]), 32'd0);
        check("left_score",    32'(Score), 32'd0);

        // all overlap: scan order and ignored second press
        do_reset();
        Player_Direction = 2'd3;
        Attack_X = 9'd100;
        Attack_Y = 9'd100;
        for (int i = 0; i < N; i++) set_enemy(i, 150, 105);
        snap();
        Attack_On = 1'b1;
        cycles(1);
        Attack_On = 1'b0;
        cycles(2);
        Attack_On = 1'b1;
        Attack_X  = 9'd400;
        cycles(1);
        Attack_On = 1'b0;
        cycles(N + 4);
        check("all_busy_cycles", 32'(busy_cnt - snap_busy), 32'd8);
        check("all_pulses", 32'(hit_log.size() - log_base), 32'd8);
        for (int k = 0; k < N; k++) begin
            if (log_base + k < hit_log.size())
                check($sformatf("all_order_%0d", k), 32'(hit_log[log_base + k]), 32'(k));
        end
        check("all_alive", 32'(Enemy_Alive), 32'hFF);
        check("all_busy_idle", 32'(Busy), 32'd0);

        // reset mid-scan; second press kills 0 and 1 before reset lands
        Attack_X = 9'd100;
        Attack_On = 1'b1;
        cycles(1);
        Attack_On = 1'b0;
        cycles(2);
        check("mid_score", 32'(Score), 32'd2);
        check("mid_busy", 32'(Busy), 32'd1);
        Reset_n = 1'b0;
        #2;
        check("mid_rst_busy",  32'(Busy), 32'd0);
        check("mid_rst_alive", 32'(Enemy_Alive), 32'hFF);
        check("mid_rst_score", 32'(Score), 32'd0);
        check("mid_rst_hit",   32'(Enemy_Hit), 32'h0);
        cycles(2);
        Reset_n = 1'b1;
        cycles(1);
        snap();
        press();
        check("post_rst_pulses", 32'(hit_log.size() - log_base), 32'd8);
        check("post_rst_alive", 32'(Enemy_Alive), 32'hFF);
        check("post_rst_score", 32'(Score), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
